// File: rtl/encoder_key_ctrl_if.sv
// rtl/encoder_key_ctrl_if.sv - encoder/key level inputs and value/event outputs bundle
interface encoder_key_ctrl_if #(
  parameter int VAL_W = 8
);
  logic             i_enc_a;
  logic             i_enc_b;
  logic             i_key;
  logic [VAL_W-1:0] o_value;
  logic             o_step_up;
  logic             o_step_dn;
  logic             o_short_press;
  logic             o_long_press;
  logic             o_repeat;

  modport master (
    output i_enc_a, i_enc_b, i_key,
    input  o_value, o_step_up, o_step_dn, o_short_press, o_long_press, o_repeat
  );

  modport slave (
    input  i_enc_a, i_enc_b, i_key,
    output o_value, o_step_up, o_step_dn, o_short_press, o_long_press, o_repeat
  );
endinterface

// File: rtl/encoder_key_ctrl.sv
// rtl/encoder_key_ctrl.sv - rotary encoder stepping, bounded value and key short/long/repeat classifier
module encoder_key_ctrl #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int VAL_W     = 8,
  parameter int VAL_MIN   = 0,
  parameter int VAL_MAX   = 255,
  parameter int VAL_INIT  = 0,
  parameter int WRAP      = 0,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input logic               i_clk,
  input logic               i_rst,
  encoder_key_ctrl_if.slave bus
);

  localparam int DIV    = CLK_FRE / 1000;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LONG_W = $clog2(LONG_MS + 1);
  localparam int REP_W  = $clog2(REPEAT_MS + 1);

  localparam logic [VAL_W-1:0] V_MIN  = VAL_W'(VAL_MIN);
  localparam logic [VAL_W-1:0] V_MAX  = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0] V_INIT = VAL_W'(VAL_INIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic              a_q;
  logic              key_q;
  logic [1:0]        state;
  logic [PRE_W-1:0]  pre;
  logic [LONG_W-1:0] ms_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [VAL_W-1:0]  value;
  logic              step_up;
  logic              step_dn;
  logic              short_press;
  logic              long_press;
  logic              repeat_p;

  logic             fall_a;
  logic             key_fall;
  logic             tick;
  logic [VAL_W-1:0] step_val;

  assign fall_a   = a_q & ~bus.i_enc_a;
  assign key_fall = key_q & ~bus.i_key;
  assign tick     = (pre == PRE_W'(DIV - 1));

  // Bound checks happen before the +/-1 so the VAL_W-bit result never overflows
  always_comb begin
    step_val = value;
    if (fall_a && bus.i_enc_b) begin
      if (value == V_MAX) step_val = (WRAP != 0) ? V_MIN : V_MAX;
      else                step_val = value + 1'b1;
    end else if (fall_a && !bus.i_enc_b) begin
      if (value == V_MIN) step_val = (WRAP != 0) ? V_MAX : V_MIN;
      else                step_val = value - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q         <= bus.i_enc_a;
      key_q       <= bus.i_key;
      state       <= S_IDLE;
      pre         <= '0;
      ms_cnt      <= '0;
      rep_cnt     <= '0;
      value       <= V_INIT;
      step_up     <= 1'b0;
      step_dn     <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_p    <= 1'b0;
    end else begin
      a_q         <= bus.i_enc_a;
      key_q       <= bus.i_key;
      step_up     <= fall_a & bus.i_enc_b;
      step_dn     <= fall_a & ~bus.i_enc_b;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_p    <= 1'b0;
      value       <= step_val;
      pre         <= (key_fall || tick) ? '0 : pre + 1'b1;

      case (state)
        S_IDLE: begin
          if (key_fall) begin
            state  <= S_PRESS;
            ms_cnt <= '0;
          end
        end
        S_PRESS: begin
          if (bus.i_key) begin
            short_press <= 1'b1;
            state       <= S_IDLE;
          end else if (tick) begin
            // Long-press reload overrides any encoder step landing in this cycle
            if (ms_cnt == LONG_W'(LONG_MS - 1)) begin
              long_press <= 1'b1;
              value      <= V_INIT;
              state      <= S_HOLD;
              rep_cnt    <= '0;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.i_key) begin
            state <= S_IDLE;
          end else if (tick) begin
            if (rep_cnt == REP_W'(REPEAT_MS - 1)) begin
              repeat_p <= 1'b1;
              rep_cnt  <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_value       = value;
  assign bus.o_step_up     = step_up;
  assign bus.o_step_dn     = step_dn;
  assign bus.o_short_press = short_press;
  assign bus.o_long_press  = long_press;
  assign bus.o_repeat      = repeat_p;

endmodule

// File: doc/encoder_key_ctrl.md
Name: encoder_key_ctrl

Overview:
- Control block behind the encoder/key debounce filters on the LCD test board.
- Turns debounced rotary-encoder A/B levels and a push-key level into direction step pulses, a bounded value register, and classified key events (short, long, auto-repeat).
- Downstream display/pattern logic reads `o_value` and the event pulses; it never sees raw encoder signals.

Parameters:
- CLK_FRE, 50_000_000, system clock frequency in Hz
- VAL_W, 8, width of value register
- VAL_MIN, 0, lower bound of value
- VAL_MAX, 255, upper bound of value (VAL_MIN < VAL_MAX < 2^VAL_W)
- VAL_INIT, 0, value after reset and after a long press
- WRAP, 0, 1 = wrap at bounds, 0 = saturate
- LONG_MS, 1000, hold time in ms that classifies a long press
- REPEAT_MS, 200, auto-repeat period in ms after a long press

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_enc_a  in  1  debounced encoder phase A level
- i_enc_b  in  1  debounced encoder phase B level
- i_key  in  1  debounced key level, active-low (0 = pressed)
- o_value  out  VAL_W  current value
- o_step_up  out  1  one-cycle pulse, clockwise detent
- o_step_dn  out  1  one-cycle pulse, counter-clockwise detent
- o_short_press  out  1  one-cycle pulse on release of a short press
- o_long_press  out  1  one-cycle pulse when hold reaches LONG_MS
- o_repeat  out  1  one-cycle pulse every REPEAT_MS while held after long press

Behaviour:
- Reset (i_rst=1 at posedge):
  - o_value=VAL_INIT; all pulse outputs 0.
  - Input history registers load the current i_enc_a / i_key levels, so there is no spurious edge after reset.
  - Key FSM goes to IDLE; ms counters clear.
  - Reset mid-press: key is treated as unpressed history; no event fires until a fresh release→press.
- Input sampling: i_enc_a and i_key are registered once (a_q, key_q). Edges are detected from the current input vs the registered value.
- Encoder decode, one step per falling edge of A (a_q=1, i_enc_a=0):
  - i_enc_b=1 → o_step_up=1 next cycle.
  - i_enc_b=0 → o_step_dn=1 next cycle.
  - Rising edges of A are ignored. Latency: 1 cycle from the edge cycle to the pulse.
- Value update, in the same cycle as the step pulse (o_value changes with the pulse):
  - Up: at VAL_MAX → VAL_MIN if WRAP else hold; otherwise +1.
  - Down: at VAL_MIN → VAL_MAX if WRAP else hold; otherwise −1.
  - Arithmetic is VAL_W bits; no intermediate overflow is permitted.
- ms tick: free-running prescaler of CLK_FRE/1000 cycles; one-cycle tick. It is restarted on every key press edge.
- Key FSM states:
  - IDLE: on falling key edge → PRESS; ms counter cleared.
  - PRESS: count ticks.
    - Key released (i_key=1) before LONG_MS → o_short_press pulse, → IDLE.
    - Count reaches LONG_MS → o_long_press pulse, o_value←VAL_INIT, → HOLD; repeat counter cleared.
  - HOLD: every REPEAT_MS ticks → o_repeat pulse. Key released → IDLE with no pulse.
- Simultaneous events:
  - Long-press load of VAL_INIT has priority over an encoder step in the same cycle. The step pulse is still emitted but the value is not modified.
  - Repeat and step in the same cycle are independent.
- Exactly one of o_step_up / o_step_dn per detent; both are never high together.
- Key events are mutually exclusive per cycle.

Test Plan:
- CLK_FRE=1000 (1 tick/cycle), defaults. Three A-falls with B=1 → three o_step_up pulses, each 1 cycle after its edge; o_value 0→3.
- VAL_MAX=3, WRAP=0, o_value=3: one up detent → o_step_up pulses, o_value stays 3. Repeat with WRAP=1 → o_value=0. Down at 0 with WRAP=1 → 3.
- Key low for 500 cycles then high → single o_short_press on release; no o_long_press; o_value unchanged.
- Key low for 1700 cycles:
  - o_long_press at ≈cycle 1000 with o_value←0.
  - o_repeat at ≈1200, 1400, 1600.
  - No o_short_press on release.
- A-fall coincident with the long-press cycle (o_value=5, VAL_INIT=0) → o_step_up pulses, o_value=0.
- i_rst asserted during HOLD with key still low, then released → all outputs 0, o_value=VAL_INIT. No event until key goes high then low again.
